mem_port_arbiter: RTL and testbench

- Shares one multi-cycle backing-memory port between two requesters: instruction fetch (IF) and the data-memory stage (DM).
- Sequences each transaction with a three-state FSM.
- Drives a stall to the pipeline while any request is outstanding.
- Sits between the pipeline's fetch/MEM stages and the single-ported memory model.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_timer.sv | 35 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared FSM state type, grant encodings and arbitration helpers for mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_DM   = 2'b10;

  // Single pending request always wins; prefer_if only breaks a tie.
  function automatic logic [1:0] arbitrate(input logic if_req, input logic dm_req,
                                           input logic prefer_if);
    logic [1:0] gnt;
    gnt = GNT_NONE;
    if (if_req && dm_req) gnt = prefer_if ? GNT_IF : GNT_DM;
    else if (dm_req)      gnt = GNT_DM;
    else if (if_req)      gnt = GNT_IF;
    return gnt;
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating wait counter for mem_port_arbiter; expired_o flags the TIMEOUT-th enabled cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int               CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (en_i && (cnt_q != '1))   cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The current cycle is the TIMEOUT-th one spent waiting when the count is TIMEOUT-1.
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between fetch (IF) and data (DM) requesters.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed DM-over-IF priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              stall_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d, win;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, resp_data;
  logic              err_q, err_d;
  logic              prefer_if, expired, mem_done;

`ifdef MEM_ARB_RR_EN
  logic [1:0] last_q;

  assign prefer_if = (last_q == GNT_DM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                    last_q <= GNT_IF;
    else if (state_q == ST_IDLE && win != GNT_NONE) last_q <= win;
  end
`else
  assign prefer_if = 1'b0;
`endif

  assign win       = arbitrate(if_req_i, dm_req_i, prefer_if);
  assign mem_done  = mem_ack_i || expired;
  assign resp_data = mem_ack_i ? mem_rdata_i : '0;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q != ST_ISSUE),
    .en_i      (state_q == ST_ISSUE),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (win != GNT_NONE) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_done)        state_d = ST_RESP;
      ST_RESP:                       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    if_ack_o  = 1'b0;
    dm_ack_o  = 1'b0;
    unique case (state_q)
      ST_ISSUE: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_q;
      end
      ST_RESP: begin
        if_ack_o = (gnt_q == GNT_IF);
        dm_ack_o = (gnt_q == GNT_DM);
      end
      default: ;
    endcase
  end

  // Request inputs matter only in IDLE; afterwards the latched copy drives the memory port.
  always_comb begin
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = win;
        if (win == GNT_DM) begin
          addr_d  = dm_addr_i;
          we_d    = dm_we_i;
          wdata_d = dm_wdata_i;
        end else if (win == GNT_IF) begin
          addr_d  = if_addr_i;
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end
      ST_ISSUE: begin
        if (mem_done) begin
          if (gnt_q == GNT_DM) dm_rdata_d = resp_data;
          else                 if_rdata_d = resp_data;
          if (!mem_ack_i) err_d = 1'b1;
        end
      end
      ST_RESP: gnt_d = GNT_NONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      gnt_q      <= GNT_NONE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign grant_o     = gnt_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed boundary steps plus randomized rounds
// scored against a transaction-level model of the arbitration and handshake rules.
module tb_mem_port_arbiter;

  localparam int         TB_TIMEOUT = 4;
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_IF   = 2'b01;
  localparam logic [1:0] G_DM   = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, err_o;
  logic [1:0]  grant_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] exp_if_rd, exp_dm_rd;
  bit          dm_rd_known;
  logic        exp_err;
  logic [1:0]  last_gnt;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .grant_o     (grant_o),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, mem_req_o, 1'b0);
    check({tag, "_acks"}, {if_ack_o, dm_ack_o}, 2'b00);
    check({tag, "_grant"}, grant_o, G_NONE);
    check({tag, "_err"}, err_o, exp_err);
    check({tag, "_if_rdata"}, if_rdata_o, exp_if_rd);
    if (dm_rd_known) check({tag, "_dm_rdata"}, dm_rdata_o, exp_dm_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_quiet(tag);
    check({tag, "_mem_we"}, mem_we_o, 1'b0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    check({tag, "_stall"}, stall_o, if_req_i | dm_req_i);
  endtask

  task automatic model_reset();
    exp_if_rd   = 32'h0;
    exp_dm_rd   = 32'h0;
    dm_rd_known = 1'b1;
    exp_err     = 1'b0;
    last_gnt    = G_IF;
  endtask

  // Model's choice when both requesters are pending in IDLE.
  function automatic logic [1:0] contested_winner();
`ifdef MEM_ARB_RR_EN
    return (last_gnt == G_DM) ? G_IF : G_DM;
`else
    return G_DM;
`endif
  endfunction

  // Waits for the grant of 'who', plays the memory with latency 'lat' (0 = never acks),
  // then checks the completion cycle. Returns at the negedge of the ack cycle.
  task automatic serve(input logic [1:0] who, input int lat, input logic [31:0] addr,
                       input logic we, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int exp_wait);
    int          waited;
    int          issue;
    bit          fire;
    logic [31:0] exp_rd;
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
    end while (mem_req_o !== 1'b1 && waited < 12);
    check("mem_req_latency", waited, exp_wait);
    check("grant_issue", grant_o, who);
    last_gnt = who;
    issue = 0;
    forever begin
      issue++;
      check("mem_req_hi", mem_req_o, 1'b1);
      check("mem_addr", mem_addr_o, addr);
      check("mem_we", mem_we_o, we);
      if (we) check("mem_wdata", mem_wdata_o, wdata);
      check("stall_issue", stall_o, if_req_i | dm_req_i);
      check("acks_issue", {if_ack_o, dm_ack_o}, 2'b00);
      fire        = (issue == lat);
      mem_ack_i   = fire;
      mem_rdata_i = fire ? rdata : $urandom;
      // Winner's inputs wander after grant; the port must keep the latched values.
      if (who == G_DM) begin
        dm_addr_i  = $urandom;
        dm_wdata_i = $urandom;
        dm_we_i    = 1'($urandom);
      end else begin
        if_addr_i = $urandom;
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (fire || (lat == 0 && issue == TB_TIMEOUT) || issue >= 40) break;
    end
    exp_rd = (lat == 0) ? 32'h0 : rdata;
    if (lat == 0) exp_err = 1'b1;
    check("mem_req_resp", mem_req_o, 1'b0);
    check("if_ack", if_ack_o, who == G_IF);
    check("dm_ack", dm_ack_o, who == G_DM);
    check("grant_resp", grant_o, who);
    check("err", err_o, exp_err);
    check("stall_resp", stall_o, (if_req_i && who != G_IF) || (dm_req_i && who != G_DM));
    if (who == G_IF) begin
      exp_if_rd = exp_rd;
      check("if_rdata", if_rdata_o, exp_if_rd);
      if (dm_rd_known) check("dm_rdata_hold", dm_rdata_o, exp_dm_rd);
    end else begin
      if (!we) begin
        exp_dm_rd   = exp_rd;
        dm_rd_known = 1'b1;
        check("dm_rdata", dm_rdata_o, exp_dm_rd);
      end else begin
        dm_rd_known = 1'b0;
      end
      check("if_rdata_hold", if_rdata_o, exp_if_rd);
    end
  endtask

  // One arbitration round starting from IDLE: raise the chosen requests together and
  // serve them in the order the model predicts.
  task automatic round(input bit do_if, input bit do_dm, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] dwd, input logic dwe,
                       input int lat_a, input int lat_b,
                       input logic [31:0] rd_a, input logic [31:0] rd_b);
    logic [1:0] first;
    @(negedge clk_i);
    check_quiet("idle");
    if_req_i   = do_if;
    if_addr_i  = ia;
    dm_req_i   = do_dm;
    dm_addr_i  = da;
    dm_wdata_i = dwd;
    dm_we_i    = dwe;
    #1;
    check("stall_req", stall_o, do_if | do_dm);
    if (do_if && do_dm) first = contested_winner();
    else if (do_dm)     first = G_DM;
    else                first = G_IF;
    if (first == G_DM) begin
      serve(G_DM, lat_a, da, dwe, dwd, rd_a, 1);
      dm_req_i = 1'b0;
      if (do_if) begin
        serve(G_IF, lat_b, ia, 1'b0, 32'h0, rd_b, 2);
        if_req_i = 1'b0;
      end
    end else begin
      serve(G_IF, lat_a, ia, 1'b0, 32'h0, rd_a, 1);
      if_req_i = 1'b0;
      if (do_dm) begin
        serve(G_DM, lat_b, da, dwe, dwd, rd_b, 2);
        dm_req_i = 1'b0;
      end
    end
  endtask

  initial begin
    rst_i       = 1'b0;
    if_req_i    = 1'b0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    mem_ack_i   = 1'b0;
    if_addr_i   = 32'h0;
    dm_addr_i   = 32'h0;
    dm_wdata_i  = 32'h0;
    mem_rdata_i = 32'h0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b1;

    // Stale ack right after reset and ack while idle are ignored
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check_quiet("idle_ack");
    end

    // IF-only read
    round(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 3, 0, 32'hDEAD_BEEF, 32'h0);

    // Contested: DM write vs IF read
    round(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0020, 32'h1234_5678, 1'b1, 2, 3,
          32'h5555_AAAA, 32'h0BAD_CAFE);

    // DM alone leaves last grant = DM, then contest again
    round(1'b0, 1'b1, 32'h0, 32'h0000_0024, 32'h0, 1'b0, 1, 0, 32'h1111_2222, 32'h0);
    round(1'b1, 1'b1, 32'h0000_0044, 32'h0000_0028, 32'hA5A5_5A5A, 1'b0, 4, 1,
          32'h3333_4444, 32'h7777_8888);

    // IF holds req across its ack: two back-to-back fetches
    @(negedge clk_i);
    check_quiet("b2b_idle");
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0004;
    serve(G_IF, 2, 32'h0000_0004, 1'b0, 32'h0, 32'h0000_0A04, 1);
    if_addr_i = 32'h0000_0008;
    serve(G_IF, 1, 32'h0000_0008, 1'b0, 32'h0, 32'h0000_0A08, 2);
    if_req_i = 1'b0;

    // IF request raised and withdrawn while DM is in flight is dropped
    @(negedge clk_i);
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h0000_0030;
    @(negedge clk_i);
    check("wd_issue", mem_req_o, 1'b1);
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0080;
    @(negedge clk_i);
    if_req_i = 1'b0;
    serve(G_DM, 1, 32'h0000_0030, 1'b0, 32'h0, 32'h6666_0030, 1);
    dm_req_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      check_quiet("withdrawn");
    end

    // Randomized rounds
    for (int i = 0; i < 24; i++) begin
      int          mode;
      logic [31:0] ia, da;
      mode = $urandom_range(0, 2);
      ia   = $urandom & 32'hFFFF_FFFC;
      da   = $urandom & 32'hFFFF_FFFC;
      round(mode != 1, mode != 0, ia, da, $urandom, 1'($urandom),
            $urandom_range(1, TB_TIMEOUT), $urandom_range(1, TB_TIMEOUT), $urandom, $urandom);
    end

    // Timeout: memory never acks a DM read
    round(1'b0, 1'b1, 32'h0, 32'h0000_0050, 32'h0, 1'b0, 0, 0, 32'hFFFF_FFFF, 32'h0);
    // err stays set through a normal transaction
    round(1'b1, 1'b0, 32'h0000_0060, 32'h0, 32'h0, 1'b0, 2, 0, 32'h1357_9BDF, 32'h0);

    // Asynchronous reset in the middle of ISSUE, then a stale ack
    @(negedge clk_i);
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0100;
    @(negedge clk_i);
    check("pre_rst_issue", mem_req_o, 1'b1);
    #2;
    rst_i = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
    if_req_i = 1'b0;
    @(negedge clk_i);
    rst_i       = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBEEF_0001;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check_quiet("post_rst");
    end

    // Operation resumes normally after reset
    round(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0300, 32'h2468_ACE0, 1'b1, 3, 2,
          32'h0F0F_0F0F, 32'hF0F0_F0F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
